dram_read_engine: RTL and testbench

- AXI4 read-master responder that serves the frame pipeline's DRAM read request interface (kick / busy / read_num / read_addr → buf_dout / buf_we).
- Converts one request of N 32-bit words into one or more INCR bursts on a 32-bit AXI4 read channel.
- Streams returned beats straight to the requester's line FIFO.
- Sits between the image-processing copy controllers and the MIG/AXI interconnect.

---
 rtl/dram_if_pkg.sv | 17 +
 rtl/burst_len_calc.sv | 25 ++
 rtl/dram_read_engine.sv | 145 ++++++++++++++
 tb/tb_dram_read_engine.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_if_pkg.sv
// Shared types and constants for the DRAM read engine and its burst-length helper.
package dram_if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         PAGE_BYTES     = 4096;
    localparam int         WORD_BYTES     = 4;

endpackage

// File: rtl/burst_len_calc.sv
// Combinational burst sizing: min(remaining words, MAX_BURST, words left in the 4 KB page).
// Zero latency; no handshake, the caller registers the result.
module burst_len_calc
    import dram_if_pkg::*;
#(
    parameter int MAX_BURST = 64
)(
    input  logic [31:0] remain_i,
    input  logic [11:0] page_off_i,
    output logic [8:0]  beats_o
);

    logic [12:0] dist_bytes;
    logic [10:0] dist_words;
    logic [8:0]  cap;

    always_comb begin
        dist_bytes = 13'(PAGE_BYTES) - {1'b0, page_off_i};
        dist_words = 11'(dist_bytes >> $clog2(WORD_BYTES));
        // A page-aligned address yields 1024 words, so MAX_BURST (<=256) always wins there.
        cap        = (11'(MAX_BURST) < dist_words) ? 9'(MAX_BURST) : dist_words[8:0];
        beats_o    = (remain_i < {23'd0, cap}) ? remain_i[8:0] : cap;
    end

endmodule

// File: rtl/dram_read_engine.sv
// Splits a kick/read_num/read_addr request into 4 KB-safe AXI4 INCR bursts, one AR outstanding; R beats reach buf_dout/buf_we 1 cycle later.
// No backpressure: rready is held high in DATA. DRAM_READ_ERR_EN adds a sticky rd_err on SLVERR/DECERR beats.
module dram_read_engine
    import dram_if_pkg::*;
#(
    parameter int MAX_BURST = 64,
    parameter int ADDR_W    = 32
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic              kick,
    output logic              busy,
    input  logic [31:0]       read_num,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [31:0]       buf_dout,
    output logic              buf_we,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic              rd_err
);

    state_t            state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [31:0]       remain_q;
    logic [8:0]        beats_q;
    logic [8:0]        beats_d;
    logic [7:0]        arlen_q;
    logic              arvalid_q;
    logic              rready_q;
    logic              busy_q;
    logic              buf_we_q;
    logic [31:0]       buf_dout_q;
    logic              rd_err_q;

    burst_len_calc #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_len_calc (
        .remain_i   (remain_q),
        .page_off_i (cur_addr_q[11:0]),
        .beats_o    (beats_d)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            araddr_q   <= '0;
            remain_q   <= '0;
            beats_q    <= '0;
            arlen_q    <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            busy_q     <= 1'b0;
            buf_we_q   <= 1'b0;
            buf_dout_q <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            buf_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (kick) begin
                        cur_addr_q <= read_addr & ~ADDR_W'(WORD_BYTES - 1);
                        remain_q   <= read_num;
                        busy_q     <= 1'b1;
                        state_q    <= ST_CALC;
`ifdef DRAM_READ_ERR_EN
                        rd_err_q   <= 1'b0;
`endif
                    end
                end
                ST_CALC: begin
                    if (remain_q == 32'd0) begin
                        state_q <= ST_DONE;
                    end else begin
                        araddr_q  <= cur_addr_q;
                        arlen_q   <= 8'(beats_d - 9'd1);
                        beats_q   <= beats_d;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q  <= 1'b0;
                        rready_q   <= 1'b1;
                        cur_addr_q <= cur_addr_q + ADDR_W'({beats_q, 2'b00});
                        remain_q   <= remain_q - 32'(beats_q);
                        state_q    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (m_axi_rvalid) begin
                        buf_we_q   <= 1'b1;
                        buf_dout_q <= m_axi_rdata;
`ifdef DRAM_READ_ERR_EN
                        if (m_axi_rresp[1]) begin
                            rd_err_q <= 1'b1;
                        end
`endif
                        // rlast alone ends the burst; the beat count is not cross-checked.
                        if (m_axi_rlast) begin
                            rready_q <= 1'b0;
                            state_q  <= ST_CALC;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef DRAM_READ_ERR_EN
    logic unused_rresp;
    assign unused_rresp = ^m_axi_rresp;
`endif

    assign busy          = busy_q;
    assign buf_dout      = buf_dout_q;
    assign buf_we        = buf_we_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign rd_err        = rd_err_q;

endmodule

// File: tb/tb_dram_read_engine.sv
// Directed bench for dram_read_engine: behavioural AXI read slave, buf_we monitor, hand-computed expectations.
module tb_dram_read_engine;

    localparam logic [31:0] PAT = 32'hC0DE_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        kick = 1'b0;
    logic        busy;
    logic [31:0] read_num = '0;
    logic [31:0] read_addr = '0;
    logic [31:0] buf_dout;
    logic        buf_we;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic        rd_err;

    dram_read_engine #(
        .MAX_BURST (64),
        .ADDR_W    (32)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .kick          (kick),
        .busy          (busy),
        .read_num      (read_num),
        .read_addr     (read_addr),
        .buf_dout      (buf_dout),
        .buf_we        (buf_we),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .rd_err        (rd_err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [31:0] ar_addr_q [$];
    logic [7:0]  ar_len_q  [$];
    logic [31:0] data_q    [$];
    int          arvalid_cyc = 0;

    int          ar_hold    = 0;
    int          burst_left = 0;
    int          beat_idx   = 0;
    int          err_beat   = -1;
    logic [31:0] r_addr     = '0;
    bit          ar_seen    = 1'b0;
    logic [31:0] ar_ref_addr;
    logic [7:0]  ar_ref_len;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // AXI read slave: drives on the falling edge, so values are stable at the next rising edge.
    initial begin
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                burst_left    = 0;
                ar_seen       = 1'b0;
                m_axi_rvalid  = 1'b0;
                m_axi_rlast   = 1'b0;
                m_axi_rresp   = 2'b00;
                m_axi_arready = 1'b1;
            end else begin
                if (burst_left > 0) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = r_addr ^ PAT;
                    m_axi_rlast  = (burst_left == 1);
                    m_axi_rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
                    if (m_axi_rready) begin
                        burst_left--;
                        r_addr += 32'd4;
                        beat_idx++;
                    end
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    m_axi_rresp  = 2'b00;
                end
                m_axi_arready = (ar_hold == 0);
                if (m_axi_arvalid) begin
                    if (!ar_seen) begin
                        ar_seen     = 1'b1;
                        ar_ref_addr = m_axi_araddr;
                        ar_ref_len  = m_axi_arlen;
                    end else begin
                        check_eq("araddr_stable", m_axi_araddr, ar_ref_addr);
                        check_eq("arlen_stable", 32'(m_axi_arlen), 32'(ar_ref_len));
                    end
                    if (ar_hold > 0) begin
                        ar_hold--;
                    end else begin
                        ar_addr_q.push_back(m_axi_araddr);
                        ar_len_q.push_back(m_axi_arlen);
                        burst_left = int'(m_axi_arlen) + 1;
                        r_addr     = m_axi_araddr;
                        ar_seen    = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (buf_we) data_q.push_back(buf_dout);
            if (m_axi_arvalid) arvalid_cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic run_req(input logic [31:0] addr, input logic [31:0] num, input bit second_kick,
                           output int busy_cyc);
        int cyc;
        @(negedge CLK);
        data_q.delete();
        ar_addr_q.delete();
        ar_len_q.delete();
        arvalid_cyc = 0;
        beat_idx    = 0;
        kick      = 1'b1;
        read_addr = addr;
        read_num  = num;
        @(negedge CLK);
        kick     = 1'b0;
        read_num = '0;
        cyc      = 0;
        busy_cyc = 0;
        while (busy === 1'b1 && cyc < 3000) begin
            busy_cyc++;
            if (second_kick && cyc == 3) begin
                kick      = 1'b1;
                read_addr = 32'h5000;
                read_num  = 32'd32;
            end else begin
                kick = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        kick = 1'b0;
        if (cyc >= 3000) check_eq("busy_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic expect_ar(input int idx, input logic [31:0] addr, input logic [7:0] len);
        if (idx < ar_addr_q.size()) begin
            check_eq($sformatf("ar%0d_addr", idx), ar_addr_q[idx], addr);
            check_eq($sformatf("ar%0d_len", idx), 32'(ar_len_q[idx]), 32'(len));
        end else begin
            check_eq($sformatf("ar%0d_present", idx), 32'(ar_addr_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic expect_data(input logic [31:0] base, input int num);
        check_eq("buf_we_cnt", 32'(data_q.size()), 32'(num));
        for (int i = 0; i < data_q.size() && i < num; i++) begin
            check_eq($sformatf("word%0d", i), data_q[i], (base + 32'(4 * i)) ^ PAT);
        end
    endtask

    initial begin
        int bc;
        int cyc;

        // Reset values
        @(negedge CLK);
        @(negedge CLK);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_buf_we", 32'(buf_we), 32'd0);
        check_eq("rst_buf_dout", buf_dout, 32'd0);
        check_eq("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
        check_eq("rst_araddr", m_axi_araddr, 32'd0);
        check_eq("rst_arlen", 32'(m_axi_arlen), 32'd0);
        check_eq("rst_rready", 32'(m_axi_rready), 32'd0);
        check_eq("rst_rd_err", 32'(rd_err), 32'd0);
        check_eq("arsize", 32'(m_axi_arsize), 32'd2);
        check_eq("arburst", 32'(m_axi_arburst), 32'd1);
        RST = 1'b0;

        // Single full burst: CALC + ADDR + 64 beats + CALC + DONE
        run_req(32'h0, 32'd64, 1'b0, bc);
        check_eq("t1_ar_cnt", 32'(ar_addr_q.size()), 32'd1);
        expect_ar(0, 32'h0, 8'd63);
        expect_data(32'h0, 64);
        check_eq("t1_busy_cyc", 32'(bc), 32'd68);

        // 200 words from 0x100: 64/64/64/8
        run_req(32'h100, 32'd200, 1'b0, bc);
        check_eq("t2_ar_cnt", 32'(ar_addr_q.size()), 32'd4);
        expect_ar(0, 32'h100, 8'd63);
        expect_ar(1, 32'h200, 8'd63);
        expect_ar(2, 32'h300, 8'd63);
        expect_ar(3, 32'h400, 8'd7);
        expect_data(32'h100, 200);
        check_eq("t2_busy_cyc", 32'(bc), 32'd210);

        // 4 KB crossing, with low address bits that must be ignored
        run_req(32'hFC3, 32'd64, 1'b0, bc);
        check_eq("t3_ar_cnt", 32'(ar_addr_q.size()), 32'd2);
        expect_ar(0, 32'hFC0, 8'd15);
        expect_ar(1, 32'h1000, 8'd47);
        expect_data(32'hFC0, 64);
        check_eq("t3_busy_cyc", 32'(bc), 32'd70);

        // Zero-length request
        run_req(32'h800, 32'd0, 1'b0, bc);
        check_eq("t4_busy_cyc", 32'(bc), 32'd2);
        check_eq("t4_arvalid_cyc", 32'(arvalid_cyc), 32'd0);
        check_eq("t4_buf_we_cnt", 32'(data_q.size()), 32'd0);

        // arready stalled 10 cycles, plus a kick while busy that must be ignored
        ar_hold = 10;
        run_req(32'h2000, 32'd4, 1'b1, bc);
        check_eq("t5_ar_cnt", 32'(ar_addr_q.size()), 32'd1);
        expect_ar(0, 32'h2000, 8'd3);
        expect_data(32'h2000, 4);
        check_eq("t5_arvalid_cyc", 32'(arvalid_cyc), 32'd11);
        check_eq("t5_busy_cyc", 32'(bc), 32'd18);
        repeat (3) @(negedge CLK);
        check_eq("t5_busy_after", 32'(busy), 32'd0);
        check_eq("t5_no_extra_ar", 32'(arvalid_cyc), 32'd11);

        // Reset in the middle of a data phase
        data_q.delete();
        kick      = 1'b1;
        read_addr = 32'h3000;
        read_num  = 32'd64;
        @(negedge CLK);
        kick = 1'b0;
        cyc  = 0;
        while (data_q.size() < 20 && cyc < 500) begin
            @(negedge CLK);
            cyc++;
        end
        if (cyc >= 500) check_eq("t6_timeout", 32'(cyc), 32'd0);
        check_eq("t6_busy_pre", 32'(busy), 32'd1);
        #2 RST = 1'b1;
        #1;
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_buf_we", 32'(buf_we), 32'd0);
        check_eq("t6_buf_dout", buf_dout, 32'd0);
        check_eq("t6_arvalid", 32'(m_axi_arvalid), 32'd0);
        check_eq("t6_rready", 32'(m_axi_rready), 32'd0);
        check_eq("t6_araddr", m_axi_araddr, 32'd0);
        check_eq("t6_arlen", 32'(m_axi_arlen), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        run_req(32'h40, 32'd8, 1'b0, bc);
        check_eq("t6_ar_cnt", 32'(ar_addr_q.size()), 32'd1);
        expect_ar(0, 32'h40, 8'd7);
        expect_data(32'h40, 8);
        check_eq("t6_busy_cyc", 32'(bc), 32'd12);

        // Error response on beat 5; data still forwarded
        err_beat = 5;
        run_req(32'h500, 32'd16, 1'b0, bc);
        expect_data(32'h500, 16);
        check_eq("t7_busy_cyc", 32'(bc), 32'd20);
`ifdef DRAM_READ_ERR_EN
        check_eq("t7_rd_err_set", 32'(rd_err), 32'd1);
        repeat (2) @(negedge CLK);
        check_eq("t7_rd_err_sticky", 32'(rd_err), 32'd1);
`else
        check_eq("t7_rd_err_tied", 32'(rd_err), 32'd0);
`endif
        err_beat = -1;
        run_req(32'h600, 32'd4, 1'b0, bc);
        check_eq("t7_rd_err_clear", 32'(rd_err), 32'd0);
        expect_data(32'h600, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
